sim_bus_host: RTL
=================

# sim_bus_host

Simulation-side bus initiator for `ibex_simple_system`. It accepts word-sized read/write commands over a valid/ready port and issues them on the system's host bus using the req/gnt/rvalid protocol, the same protocol that `simulator_ctrl` answers as a device. Every granted transaction is returned in order on a response port with its read data and error flag. Benches use it to preload RAM, poke SimCtrl/Timer registers and check read-back without running core firmware.

## Interface
- `RspDepth`, 2: response FIFO depth and maximum number of transactions in flight; must be ≥1.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset; one clock, asynchronous and active-low.
- `cmd_valid_i`  in  1  command offered.
- `cmd_ready_o`  out  1  command accepted this cycle when both valid and ready are high.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_addr_i`  in  32  byte address; bits [1:0] are ignored.
- `cmd_be_i`  in  4  byte enables.
- `cmd_wdata_i`  in  32  write data.
- `host_req_o`  out  1  bus request.
- `host_gnt_i`  in  1  bus grant.
- `host_we_o`  out  1  write enable.
- `host_be_o`  out  4  byte enables.
- `host_addr_o`  out  32  word address; bits [1:0] are always 0.
- `host_wdata_o`  out  32  write data.
- `host_rvalid_i`  in  1  response valid, one per grant, in grant order.
- `host_rdata_i`  in  32  response read data.
- `host_err_i`  in  1  response error, qualified by rvalid.
- `rsp_valid_o`  out  1  response available.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_we_o`  out  1  the response belongs to a write.
- `rsp_rdata_o`  out  32  read data; 0 for writes.
- `rsp_err_o`  out  1  bus error.
- `proto_err_o`  out  1  sticky flag: an rvalid arrived with nothing outstanding.
- `idle_o`  out  1  no command pending, outstanding or buffered.

## Operation
- The FSM has two states, `IDLE` and `REQ`.
- `inflight` is the sum of three terms: (state==REQ), `outstanding` (granted transactions still waiting for rvalid) and the FIFO occupancy.
- `cmd_ready_o` = (state==IDLE) && (inflight < RspDepth). It is computed combinationally from registered state only.
- Command handshake: the bus fields are registered, `host_req_o` is set and the FSM moves to `REQ`.
- In `REQ`: `host_req_o`, `host_we_o`, `host_be_o`, `host_addr_o` and `host_wdata_o` are held stable until `host_gnt_i` is high.
  - On the grant edge `host_req_o` clears, `outstanding` increments, the FIFO records `we` for the transaction, and the FSM returns to `IDLE`.
- On `host_rvalid_i` with `outstanding`>0:
  - the FIFO is pushed with {we, we ? 0 : rdata, err};
  - `outstanding` decrements.
- Grant and rvalid in the same cycle: `outstanding` is unchanged.
- On `host_rvalid_i` with `outstanding`==0: the response is dropped, `proto_err_o` sets and stays set until reset.
- The FIFO cannot overflow because credit is checked before a command is accepted. Push and pop in the same cycle are legal at any occupancy.
- The FIFO pops on `rsp_valid_o && rsp_ready_i`. Response outputs hold stable while `rsp_valid_o`=1 and `rsp_ready_i`=0.
- `idle_o` = (inflight==0).
- Reset values: every output is 0 except `idle_o`=1 and `cmd_ready_o`=1 (the latter follows combinationally from reset state).
- Reset mid-transaction: `host_req_o` drops immediately, and all counters, the FIFO and the sticky flag clear. Responses still owed by the bus are then treated as unexpected.

## Timing
- Command accepted at edge N → `host_req_o`=1 during cycle N+1.
- Grant sampled at edge M → `host_req_o`=0 from cycle M+1.
- Throughput: at most one command every 2 cycles.
- `host_rvalid_i` at edge K → `rsp_valid_o`=1 from cycle K+1. The FIFO is registered and has no fall-through.
- Minimum latency from command to response is 3 cycles, with immediate grant and rvalid one cycle after grant.
- No combinational path from any `host_*` input to any `host_*` output.

## Structure
- `sim_bus_pkg` contains:
  - `sim_bus_cmd_t` {we, addr, be, wdata};
  - `sim_bus_rsp_t` {we, rdata, err};
  - `sim_bus_state_e` {IDLE, REQ}.
- Sub-module `sim_bus_rsp_fifo`: depth `RspDepth`, holding `sim_bus_rsp_t` entries plus a `we` tag pushed at grant time, with a registered head and count output.

## Test plan
- Write 0xDEADBEEF, be=0xF, to 0x0010_0000 with immediate grant and rvalid 1 cycle later → one response we=1, rdata=0, err=0; `idle_o` returns to 1.
- Read 0x0010_0000 with gnt delayed 5 cycles → req held for 6 cycles with stable address; response rdata=0xDEADBEEF.
- RspDepth=2 with `rsp_ready_i`=0 and 3 reads offered → `cmd_ready_o` low after 2 accepts. After one pop, the third read issues, and responses come out in order.
- rvalid with err=1 → rsp_err_o=1. A spurious rvalid while idle → proto_err_o=1, FIFO unchanged.
- Address 0x0002_0003 → host_addr_o=0x0002_0000.
- Assert `rst_ni` low while req is high → `host_req_o` falls in the same cycle. After release, `idle_o`=1 and `cmd_ready_o`=1.

Source files
------------

// File: rtl/sim_bus_pkg.sv
// Shared types for the simulation-side bus initiator.
package sim_bus_pkg;

   // Command captured on the command port and driven onto the host bus.
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } sim_bus_cmd_t;

   // Response handed back on the response port.
   typedef struct packed {
      logic        we;
      logic [31:0] rdata;
      logic        err;
   } sim_bus_rsp_t;

   // IDLE: free to take a command; REQ: holding a request until granted.
   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } sim_bus_state_e;

   // Word-align a byte address by clearing the two low bits.
   function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
      return byte_addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/sim_bus_rsp_fifo.sv
// In-order response buffer. A tag queue remembers the write flag of each
// granted transaction until its rvalid arrives; the response queue then
// holds completed responses until consumed. Both queues shift toward
// slot 0, so the head is always a plain register.
module sim_bus_rsp_fifo
   import sim_bus_pkg::*;
#(
   parameter int unsigned Depth = 2,
   parameter int unsigned CW    = $clog2(Depth + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          tag_push_i,
   input  logic          tag_we_i,
   input  logic          push_i,
   input  logic [31:0]   rdata_i,
   input  logic          err_i,
   input  logic          pop_i,
   output sim_bus_rsp_t  head_o,
   output logic [CW-1:0] count_o,
   output logic [CW-1:0] outstanding_o
);

   logic         tag_reg [Depth];
   logic         tag_next [Depth];
   logic [CW-1:0] tag_cnt_reg, tag_cnt_next;
   logic [CW-1:0] tag_wr_idx;

   sim_bus_rsp_t mem_reg [Depth];
   sim_bus_rsp_t mem_next [Depth];
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [CW-1:0] mem_wr_idx;
   sim_bus_rsp_t  rsp_new;

   // A completed response consumes the oldest tag; writes report zero data.
   assign rsp_new = '{we: tag_reg[0], rdata: (tag_reg[0] ? 32'h0 : rdata_i), err: err_i};

   // Tag queue next state: shift out on response, append on grant.
   always_comb begin
      tag_next   = tag_reg;
      tag_wr_idx = tag_cnt_reg - CW'(push_i);
      if (push_i) begin
         for (int i = 0; i < int'(Depth) - 1; i++) begin
            tag_next[i] = tag_reg[i + 1];
         end
         tag_next[Depth - 1] = 1'b0;
      end
      if (tag_push_i) begin
         for (int i = 0; i < int'(Depth); i++) begin
            if (CW'(i) == tag_wr_idx) begin
               tag_next[i] = tag_we_i;
            end
         end
      end
      tag_cnt_next = tag_cnt_reg + CW'(tag_push_i) - CW'(push_i);
   end

   // Response queue next state: shift out on pop, append on response.
   always_comb begin
      mem_next   = mem_reg;
      mem_wr_idx = cnt_reg - CW'(pop_i);
      if (pop_i) begin
         for (int i = 0; i < int'(Depth) - 1; i++) begin
            mem_next[i] = mem_reg[i + 1];
         end
         mem_next[Depth - 1] = '0;
      end
      if (push_i) begin
         for (int i = 0; i < int'(Depth); i++) begin
            if (CW'(i) == mem_wr_idx) begin
               mem_next[i] = rsp_new;
            end
         end
      end
      cnt_next = cnt_reg + CW'(push_i) - CW'(pop_i);
   end

   // Storage and occupancy registers for both queues.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) begin
            tag_reg[i] <= 1'b0;
            mem_reg[i] <= '0;
         end
         tag_cnt_reg <= '0;
         cnt_reg     <= '0;
      end else begin
         tag_reg     <= tag_next;
         mem_reg     <= mem_next;
         tag_cnt_reg <= tag_cnt_next;
         cnt_reg     <= cnt_next;
      end
   end

   assign head_o        = mem_reg[0];
   assign count_o       = cnt_reg;
   assign outstanding_o = tag_cnt_reg;

endmodule

// File: rtl/sim_bus_host.sv
// Bus initiator: turns valid/ready word commands into req/gnt/rvalid host
// bus transactions and returns responses in order. Credit for a response
// slot is taken before a command is accepted, so the buffer never overflows.
module sim_bus_host
   import sim_bus_pkg::*;
#(
   parameter int unsigned RspDepth = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_addr_i,
   input  logic [3:0]  cmd_be_i,
   input  logic [31:0] cmd_wdata_i,
   output logic        host_req_o,
   input  logic        host_gnt_i,
   output logic        host_we_o,
   output logic [3:0]  host_be_o,
   output logic [31:0] host_addr_o,
   output logic [31:0] host_wdata_o,
   input  logic        host_rvalid_i,
   input  logic [31:0] host_rdata_i,
   input  logic        host_err_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_we_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        proto_err_o,
   output logic        idle_o
);

   localparam int unsigned CW = $clog2(RspDepth + 1);

   sim_bus_state_e state_reg, state_next;
   sim_bus_cmd_t   cmd_reg;
   logic           proto_err_reg;
   logic [CW-1:0]  outstanding;
   logic [CW-1:0]  fifo_count;
   logic [CW+1:0]  inflight;
   logic           accept;
   logic           grant;
   logic           rsp_push;
   logic           rsp_pop;
   sim_bus_rsp_t   head;

   // Everything that holds a response slot: pending request, awaiting rvalid, buffered.
   assign inflight = {{(CW + 1){1'b0}}, (state_reg == REQ)}
                   + {2'b00, outstanding}
                   + {2'b00, fifo_count};

   assign accept   = cmd_valid_i && cmd_ready_o;
   assign grant    = (state_reg == REQ) && host_gnt_i;
   assign rsp_push = host_rvalid_i && (outstanding != '0);
   assign rsp_pop  = rsp_valid_o && rsp_ready_i;

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next state: enter REQ on accept, return to IDLE on grant.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = REQ;
         REQ:  if (host_gnt_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs, derived from registered state only.
   always_comb begin
      host_req_o  = (state_reg == REQ);
      cmd_ready_o = (state_reg == IDLE) && (inflight < (CW + 2)'(RspDepth));
      rsp_valid_o = (fifo_count != '0);
      idle_o      = (inflight == '0);
   end

   // Capture the bus fields on accept; they stay stable through the request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cmd_reg <= '0;
      end else if (accept) begin
         cmd_reg <= '{we: cmd_we_i, addr: word_addr(cmd_addr_i), be: cmd_be_i, wdata: cmd_wdata_i};
      end
   end

   // Sticky flag for an rvalid that no granted transaction is waiting for.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         proto_err_reg <= 1'b0;
      end else if (host_rvalid_i && (outstanding == '0)) begin
         proto_err_reg <= 1'b1;
      end
   end

   sim_bus_rsp_fifo #(
      .Depth (RspDepth),
      .CW    (CW)
   ) u_rsp_fifo (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .tag_push_i    (grant),
      .tag_we_i      (cmd_reg.we),
      .push_i        (rsp_push),
      .rdata_i       (host_rdata_i),
      .err_i         (host_err_i),
      .pop_i         (rsp_pop),
      .head_o        (head),
      .count_o       (fifo_count),
      .outstanding_o (outstanding)
   );

   assign host_we_o    = cmd_reg.we;
   assign host_be_o    = cmd_reg.be;
   assign host_addr_o  = cmd_reg.addr;
   assign host_wdata_o = cmd_reg.wdata;

   assign rsp_we_o    = head.we;
   assign rsp_rdata_o = head.rdata;
   assign rsp_err_o   = head.err;
   assign proto_err_o = proto_err_reg;

endmodule
